// File: rtl/uart_word_assembler.sv
// Packs consecutive received bytes into a word behind valid/ready handshakes.
// A partial word is discarded if the gap between its bytes exceeds the inter-byte timeout.
module uart_word_assembler #(
  parameter int BYTES_PER_WORD = 4,
  parameter bit BIG_ENDIAN     = 1'b0,
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic                                  clock,
  input  logic                                  reset_n,
  input  logic [7:0]                            in_data,
  input  logic                                  in_valid,
  output logic                                  in_ready,
  output logic [8*BYTES_PER_WORD-1:0]           out_data,
  output logic                                  out_valid,
  input  logic                                  out_ready,
  output logic                                  timeout_error,
  output logic [$clog2(BYTES_PER_WORD+1)-1:0]   byte_count
);

  localparam int WW  = 8 * BYTES_PER_WORD;
  localparam int BCW = $clog2(BYTES_PER_WORD + 1);
  // A zero timeout still needs a 1-bit timer so the register is well formed.
  localparam int TW  = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [BCW-1:0] LAST_IDX  = BCW'(BYTES_PER_WORD - 1);
  localparam logic [TW-1:0]  TIMER_MAX = TW'((TIMEOUT_CYCLES > 0) ? (TIMEOUT_CYCLES - 1) : 0);
  localparam bit TIMEOUT_EN = (TIMEOUT_CYCLES > 0);

  typedef enum logic {COLLECT = 1'b0, HOLD = 1'b1} state_t;

  state_t          state_q, state_d;
  logic [BCW-1:0]  count_q, count_d;
  logic [TW-1:0]   timer_q, timer_d;
  logic [WW-1:0]   data_q, data_d;
  logic            out_valid_q, out_valid_d;
  logic            timeout_error_q, timeout_error_d;

  logic            byte_xfer;
  logic            timer_active;
  logic [WW-1:0]   data_wr;

  assign byte_xfer    = in_valid && (state_q == COLLECT);
  assign timer_active = TIMEOUT_EN && (state_q == COLLECT) && (count_q != '0);

  // Each lane captures the incoming byte when the byte position it owns is being filled.
  generate
    for (genvar gi = 0; gi < BYTES_PER_WORD; gi++) begin : g_lane
      localparam int BYTE_POS = BIG_ENDIAN ? (BYTES_PER_WORD - 1 - gi) : gi;
      assign data_wr[gi*8 +: 8] = (count_q == BCW'(BYTE_POS)) ? in_data : data_q[gi*8 +: 8];
    end
  endgenerate

  always_comb begin
    state_d         = state_q;
    count_d         = count_q;
    timer_d         = timer_q;
    data_d          = data_q;
    out_valid_d     = out_valid_q;
    timeout_error_d = 1'b0;

    case (state_q)
      COLLECT: begin
        if (byte_xfer) begin
          data_d  = data_wr;
          timer_d = '0;
          if (count_q == LAST_IDX) begin
            state_d     = HOLD;
            out_valid_d = 1'b1;
            count_d     = '0;
          end else begin
            count_d = count_q + 1'b1;
          end
        end else if (timer_active) begin
          // An arriving byte in the expiry cycle takes the branch above, so it always wins.
          if (timer_q == TIMER_MAX) begin
            count_d         = '0;
            timer_d         = '0;
            timeout_error_d = 1'b1;
          end else begin
            timer_d = timer_q + 1'b1;
          end
        end else begin
          timer_d = '0;
        end
      end

      HOLD: begin
        timer_d = '0;
        if (out_ready) begin
          state_d     = COLLECT;
          out_valid_d = 1'b0;
          data_d      = '0;
        end
      end

      default: begin
        state_d     = COLLECT;
        count_d     = '0;
        timer_d     = '0;
        data_d      = '0;
        out_valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q         <= COLLECT;
      count_q         <= '0;
      timer_q         <= '0;
      data_q          <= '0;
      out_valid_q     <= 1'b0;
      timeout_error_q <= 1'b0;
    end else begin
      state_q         <= state_d;
      count_q         <= count_d;
      timer_q         <= timer_d;
      data_q          <= data_d;
      out_valid_q     <= out_valid_d;
      timeout_error_q <= timeout_error_d;
    end
  end

  assign in_ready      = (state_q == COLLECT);
  assign out_valid     = out_valid_q;
  assign out_data      = data_q;
  assign timeout_error = timeout_error_q;
  assign byte_count    = count_q;

endmodule

// File: tb/tb_uart_word_assembler.sv
// Bench for uart_word_assembler: three instances (LE/BE 4-byte, 1-byte) share one stimulus
// stream and are compared every cycle against a byte-queue model plus hand-computed values.
module tb_uart_word_assembler;

  localparam int T = 16;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [7:0]  in_data;
  logic        in_valid;
  logic        out_ready;

  logic        rdy_le, rdy_be, rdy_one;
  logic        ov_le, ov_be, ov_one;
  logic        te_le, te_be, te_one;
  logic [31:0] od_le, od_be;
  logic [7:0]  od_one;
  logic [2:0]  bc_le, bc_be;
  logic [0:0]  bc_one;

  int tests_run = 0;
  int tests_failed = 0;

  always #5 clk = ~clk;

  uart_word_assembler #(.BYTES_PER_WORD(4), .BIG_ENDIAN(1'b0), .TIMEOUT_CYCLES(T)) dut_le (
    .clock(clk), .reset_n(rst_n), .in_data(in_data), .in_valid(in_valid), .in_ready(rdy_le),
    .out_data(od_le), .out_valid(ov_le), .out_ready(out_ready), .timeout_error(te_le),
    .byte_count(bc_le));

  uart_word_assembler #(.BYTES_PER_WORD(4), .BIG_ENDIAN(1'b1), .TIMEOUT_CYCLES(T)) dut_be (
    .clock(clk), .reset_n(rst_n), .in_data(in_data), .in_valid(in_valid), .in_ready(rdy_be),
    .out_data(od_be), .out_valid(ov_be), .out_ready(out_ready), .timeout_error(te_be),
    .byte_count(bc_be));

  uart_word_assembler #(.BYTES_PER_WORD(1), .BIG_ENDIAN(1'b0), .TIMEOUT_CYCLES(T)) dut_one (
    .clock(clk), .reset_n(rst_n), .in_data(in_data), .in_valid(in_valid), .in_ready(rdy_one),
    .out_data(od_one), .out_valid(ov_one), .out_ready(out_ready), .timeout_error(te_one),
    .byte_count(bc_one));

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // ---------------- behavioural model: bytes gathered per instance, timeout by elapsed cycles
  int          bpw_m [3] = '{4, 4, 1};
  bit          be_m  [3] = '{1'b0, 1'b1, 1'b0};
  logic [7:0]  part  [3][4];
  int          cnt   [3];
  bit          hold  [3];
  logic [31:0] word  [3];
  bit          err   [3];
  longint      last  [3];
  longint      cyc;

  function automatic logic [31:0] pack(input int k);
    logic [31:0] w;
    w = 32'h0;
    for (int i = 0; i < bpw_m[k]; i++) begin
      if (be_m[k]) w = w | (32'(part[k][i]) << (8 * (bpw_m[k] - 1 - i)));
      else         w = w | (32'(part[k][i]) << (8 * i));
    end
    return w;
  endfunction

  initial begin
    cyc = 0;
    for (int k = 0; k < 3; k++) begin
      cnt[k] = 0; hold[k] = 0; word[k] = 0; err[k] = 0; last[k] = 0;
    end
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        cyc = 0;
        for (int k = 0; k < 3; k++) begin
          cnt[k] = 0; hold[k] = 0; word[k] = 0; err[k] = 0; last[k] = 0;
        end
      end else begin
        cyc++;
        for (int k = 0; k < 3; k++) begin
          err[k] = 0;
          if (hold[k]) begin
            if (out_ready) begin
              hold[k] = 0;
              word[k] = 0;
            end
          end else if (in_valid) begin
            part[k][cnt[k]] = in_data;
            cnt[k]++;
            last[k] = cyc;
            if (cnt[k] == bpw_m[k]) begin
              word[k] = pack(k);
              hold[k] = 1;
              cnt[k]  = 0;
            end
          end else if (cnt[k] > 0 && (cyc - last[k]) >= T) begin
            cnt[k] = 0;
            err[k] = 1;
          end
        end
      end
    end
  end

  // ---------------- per-cycle compare against the model
  initial begin
    logic        r, v, t;
    logic [31:0] d, b;
    forever begin
      @(negedge clk);
      for (int k = 0; k < 3; k++) begin
        case (k)
          0:       begin r = rdy_le;  v = ov_le;  t = te_le;  d = od_le;         b = 32'(bc_le);  end
          1:       begin r = rdy_be;  v = ov_be;  t = te_be;  d = od_be;         b = 32'(bc_be);  end
          default: begin r = rdy_one; v = ov_one; t = te_one; d = 32'(od_one);   b = 32'(bc_one); end
        endcase
        check($sformatf("inst%0d in_ready", k), 32'(r), 32'(!hold[k]));
        check($sformatf("inst%0d out_valid", k), 32'(v), 32'(hold[k]));
        check($sformatf("inst%0d timeout_error", k), 32'(t), 32'(err[k]));
        check($sformatf("inst%0d byte_count", k), b, 32'(cnt[k]));
        if (hold[k]) check($sformatf("inst%0d out_data", k), d, word[k]);
      end
    end
  end

  task automatic drive(input logic v, input logic [7:0] d);
    @(negedge clk);
    in_valid = v;
    in_data  = d;
  endtask

  // ---------------- directed stimulus with literal expectations
  initial begin
    int pulses, pos;
    logic [31:0] held;
    rst_n = 1'b0; in_valid = 1'b0; in_data = 8'h00; out_ready = 1'b1;
    repeat (2) @(negedge clk);
    check("reset out_valid", 32'(ov_le), 32'd0);
    check("reset in_ready", 32'(rdy_le), 32'd1);
    check("reset byte_count", 32'(bc_le), 32'd0);
    check("reset out_data", od_le, 32'h0);
    check("reset timeout_error", 32'(te_be), 32'd0);
    rst_n = 1'b1;
    drive(0, 8'h00);

    // Back-to-back word, both endiannesses
    drive(1, 8'h11); drive(1, 8'h22); drive(1, 8'h33); drive(1, 8'h44);
    drive(0, 8'h00);
    check("le word", od_le, 32'h44332211);
    check("be word", od_be, 32'h11223344);
    check("le valid latency", 32'(ov_le), 32'd1);
    drive(0, 8'h00);
    check("le valid one cycle", 32'(ov_le), 32'd0);

    // Backpressure with garbage held on the input
    out_ready = 1'b0;
    drive(1, 8'hAA); drive(1, 8'hBB); drive(1, 8'hCC); drive(1, 8'hDD);
    held = 32'hDDCCBBAA;
    for (int i = 0; i < 20; i++) begin
      drive(1, 8'h55);
      check("bp in_ready low", 32'(rdy_le), 32'd0);
      check("bp data stable", od_le, held);
    end
    out_ready = 1'b1;
    drive(1, 8'h55);
    check("bp release in_ready", 32'(rdy_le), 32'd1);
    check("bp release count", 32'(bc_le), 32'd0);
    drive(1, 8'h66);
    check("bp byte0 taken", 32'(bc_le), 32'd1);
    drive(1, 8'h77); drive(1, 8'h88);
    drive(0, 8'h00);
    check("bp next word", od_le, 32'h88776655);
    drive(0, 8'h00); drive(0, 8'h00);

    // Timeout after two bytes, then a clean word
    drive(1, 8'h01); drive(1, 8'h02);
    pulses = 0; pos = -1;
    for (int j = 0; j < 20; j++) begin
      drive(0, 8'h00);
      if (te_le) begin
        pulses++;
        if (pos < 0) pos = j;
      end
    end
    check("timeout pulse count", 32'(pulses), 32'd1);
    check("timeout pulse position", 32'(pos), 32'd16);
    check("timeout count cleared", 32'(bc_le), 32'd0);
    drive(1, 8'h0A); drive(1, 8'h0B); drive(1, 8'h0C); drive(1, 8'h0D);
    drive(0, 8'h00);
    check("post-timeout word", od_le, 32'h0D0C0B0A);
    drive(0, 8'h00);

    // Third byte lands in the expiry cycle
    drive(1, 8'h01); drive(1, 8'h02);
    for (int j = 0; j < 15; j++) drive(0, 8'h00);
    drive(1, 8'h03);
    drive(0, 8'h00);
    check("expiry byte kept", 32'(bc_le), 32'd3);
    check("expiry no error", 32'(te_le), 32'd0);
    drive(1, 8'h04);
    drive(0, 8'h00);
    check("expiry word", od_le, 32'h04030201);
    drive(0, 8'h00);

    // Reset mid-word
    drive(1, 8'hA1); drive(1, 8'hA2);
    drive(0, 8'h00);
    check("pre-reset count", 32'(bc_le), 32'd2);
    #2 rst_n = 1'b0;
    #1;
    check("reset mid-word count", 32'(bc_le), 32'd0);
    check("reset mid-word in_ready", 32'(rdy_le), 32'd1);
    @(negedge clk); rst_n = 1'b1;

    // Reset during HOLD
    out_ready = 1'b0;
    drive(1, 8'hC1); drive(1, 8'hC2); drive(1, 8'hC3); drive(1, 8'hC4);
    drive(0, 8'h00);
    check("pre-reset hold", 32'(ov_le), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("reset hold out_valid", 32'(ov_le), 32'd0);
    check("reset hold in_ready", 32'(rdy_le), 32'd1);
    check("reset hold count", 32'(bc_le), 32'd0);
    check("reset hold no error", 32'(te_le), 32'd0);
    @(negedge clk); rst_n = 1'b1; out_ready = 1'b1;
    drive(1, 8'hB1); drive(1, 8'hB2); drive(1, 8'hB3); drive(1, 8'hB4);
    drive(0, 8'h00);
    check("post-reset le word", od_le, 32'hB4B3B2B1);
    check("post-reset be word", od_be, 32'hB1B2B3B4);
    repeat (3) drive(0, 8'h00);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
